// File: rtl/fpga_status_indicator.sv
// fpga_status_indicator: per-channel LED driver with a shared tick prescaler,
// a blink generator and a latched exit-code flash sequencer.
module fpga_status_indicator #(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned TICK_DIV  = 12_500_000,
  parameter int unsigned HALF_W    = 8,
  parameter int unsigned CODE_W    = 4,
  parameter int unsigned GAP_TICKS = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [2*NUM_CH-1:0] mode_i,
  input  logic [HALF_W-1:0]   blink_half_i,
  input  logic [31:0]         exit_value_i,
  input  logic                exit_valid_i,
  output logic [NUM_CH-1:0]   led_o,
  output logic                tick_o,
  output logic                exit_latched_o,
  output logic [CODE_W-1:0]   exit_code_o
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned GAP_W = $clog2(GAP_TICKS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SOLID,
    S_FLASH_ON,
    S_FLASH_OFF,
    S_GAP
  } state_t;

  logic [CNT_W-1:0]  pre_cnt_q;
  logic [HALF_W-1:0] half_cnt_q;
  logic [HALF_W-1:0] half_lim_c;
  logic              phase_q;
  logic              capture_c;
  state_t            state_q, state_d;
  logic [CODE_W-1:0] flash_q, flash_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              exit_on_c;
  logic [NUM_CH-1:0] led_d_c;
  logic              unused_exit_c;

  // Upper exit_value bits carry no meaning for the indicator.
  assign unused_exit_c = ^exit_value_i[31:CODE_W];

  // Prescaler; tick_o is registered one cycle early so it lines up with the
  // counter's terminal value.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pre_cnt_q <= '0;
      tick_o    <= 1'b0;
    end else begin
      if (pre_cnt_q == CNT_W'(TICK_DIV - 1)) pre_cnt_q <= '0;
      else                                   pre_cnt_q <= pre_cnt_q + CNT_W'(1);
      tick_o <= (pre_cnt_q == CNT_W'(TICK_DIV - 2));
    end
  end

  // A zero half-period behaves as one tick.
  assign half_lim_c = (blink_half_i == '0) ? '0 : blink_half_i - HALF_W'(1);

  // Blink generator; >= compare keeps a shrinking half-period from running the counter long.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      half_cnt_q <= '0;
      phase_q    <= 1'b0;
    end else if (tick_o) begin
      if (half_cnt_q >= half_lim_c) begin
        half_cnt_q <= '0;
        phase_q    <= ~phase_q;
      end else begin
        half_cnt_q <= half_cnt_q + HALF_W'(1);
      end
    end
  end

  assign capture_c = exit_valid_i & ~exit_latched_o;

  // Exit value latch, first valid only until reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      exit_latched_o <= 1'b0;
      exit_code_o    <= '0;
    end else if (capture_c) begin
      exit_latched_o <= 1'b1;
      exit_code_o    <= exit_value_i[CODE_W-1:0];
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      flash_q <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      flash_q <= flash_d;
      gap_q   <= gap_d;
    end
  end

  // Sequencer next state; the capture cycle ignores any coincident tick.
  always_comb begin
    state_d   = state_q;
    flash_d   = flash_q;
    gap_d     = gap_q;
    exit_on_c = (state_q == S_SOLID) || (state_q == S_FLASH_ON);
    case (state_q)
      S_IDLE: begin
        if (capture_c) begin
          if (exit_value_i[CODE_W-1:0] == '0) begin
            state_d = S_SOLID;
          end else begin
            state_d = S_FLASH_ON;
            flash_d = '0;
          end
        end
      end
      S_SOLID: begin
        state_d = S_SOLID;
      end
      S_FLASH_ON: begin
        if (tick_o) state_d = S_FLASH_OFF;
      end
      S_FLASH_OFF: begin
        if (tick_o) begin
          if (flash_q == exit_code_o - CODE_W'(1)) begin
            state_d = S_GAP;
            gap_d   = '0;
          end else begin
            state_d = S_FLASH_ON;
            flash_d = flash_q + CODE_W'(1);
          end
        end
      end
      S_GAP: begin
        if (tick_o) begin
          if (gap_q == GAP_W'(GAP_TICKS - 1)) begin
            state_d = S_FLASH_ON;
            flash_d = '0;
          end else begin
            gap_d = gap_q + GAP_W'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Per-channel source selection.
  always_comb begin
    led_d_c = '0;
    for (int k = 0; k < int'(NUM_CH); k++) begin
      case (mode_i[2*k +: 2])
        2'b00:   led_d_c[k] = 1'b0;
        2'b01:   led_d_c[k] = 1'b1;
        2'b10:   led_d_c[k] = phase_q;
        default: led_d_c[k] = exit_on_c;
      endcase
    end
  end

  // Registered LED drive.
  always_ff @(posedge clk_i) begin
    if (rst_i) led_o <= '0;
    else       led_o <= led_d_c;
  end

endmodule

// File: tb/tb_fpga_status_indicator.sv
// tb_fpga_status_indicator: vector table, directed exit/reset sequences and a
// randomized run against a tick-arithmetic reference model.
module tb_fpga_status_indicator;

  localparam int TD  = 4;
  localparam int GAP = 3;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [7:0]  mode_i;
  logic [7:0]  blink_half_i;
  logic [31:0] exit_value_i;
  logic        exit_valid_i;
  logic [3:0]  led_o;
  logic        tick_o;
  logic        exit_latched_o;
  logic [3:0]  exit_code_o;

  int t;
  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [7:0] mode;
    logic [3:0] exp_led;
  } vec_t;
  vec_t vecs [6];

  fpga_status_indicator #(
    .NUM_CH(4), .TICK_DIV(TD), .HALF_W(8), .CODE_W(4), .GAP_TICKS(GAP)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .mode_i(mode_i), .blink_half_i(blink_half_i),
    .exit_value_i(exit_value_i), .exit_valid_i(exit_valid_i), .led_o(led_o),
    .tick_o(tick_o), .exit_latched_o(exit_latched_o), .exit_code_o(exit_code_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0d: got 0x%0h, expected 0x%0h", name, t, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(negedge clk_i);
    t++;
  endtask

  // Three cycles of reset with all outputs checked low; returns at cycle 0.
  task automatic do_reset();
    rst_i        = 1'b1;
    exit_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("reset_led", 32'(led_o), 32'd0);
      chk("reset_tick", 32'(tick_o), 32'd0);
      chk("reset_latched", 32'(exit_latched_o), 32'd0);
      chk("reset_code", 32'(exit_code_o), 32'd0);
    end
    rst_i = 1'b0;
    t     = 0;
  endtask

  // Blink phase during cycle s (s counted from reset release).
  function automatic logic phase_at(input int s, input int h);
    return ((s / TD) / h) % 2 == 1;
  endfunction

  // Exit-sequencer lit state during cycle s, given capture cycle cap.
  function automatic logic exit_lit(input int s, input int cap, input int code);
    int k;
    int p;
    if (cap < 0 || s <= cap) return 1'b0;
    if (code == 0) return 1'b1;
    k = s / TD - (cap + 1) / TD;
    p = k % (2 * code + GAP);
    return (p < 2 * code) && (p % 2 == 0);
  endfunction

  task automatic run_random(input int cycles, input logic [7:0] bh);
    int         cap;
    int         cap_code;
    int         h;
    logic [7:0] prev_mode;
    logic [3:0] exp_led;
    logic [1:0] m;
    blink_half_i = bh;
    mode_i       = 8'($urandom);
    h            = (bh == 0) ? 1 : int'(bh);
    do_reset();
    cap       = -1;
    cap_code  = 0;
    prev_mode = mode_i;
    while (t < cycles) begin
      exp_led = '0;
      if (t > 0) begin
        for (int k = 0; k < 4; k++) begin
          m = prev_mode[2*k +: 2];
          case (m)
            2'b00: exp_led[k] = 1'b0;
            2'b01: exp_led[k] = 1'b1;
            2'b10: exp_led[k] = phase_at(t - 1, h);
            default: exp_led[k] = exit_lit(t - 1, cap, cap_code);
          endcase
        end
      end
      chk("rand_led", 32'(led_o), 32'(exp_led));
      chk("rand_tick", 32'(tick_o), 32'(t % TD == TD - 1));
      chk("rand_latched", 32'(exit_latched_o), 32'(cap >= 0 && t > cap));
      chk("rand_code", 32'(exit_code_o), (cap >= 0 && t > cap) ? 32'(cap_code) : 32'd0);
      if ($urandom_range(0, 3) == 0) mode_i = 8'($urandom);
      exit_value_i = $urandom;
      exit_valid_i = (t > 10) && ($urandom_range(0, 39) == 0);
      if (exit_valid_i && cap < 0) begin
        cap      = t;
        cap_code = int'(exit_value_i[3:0]);
      end
      prev_mode = mode_i;
      next_cycle();
    end
    exit_valid_i = 1'b0;
  endtask

  initial begin
    vecs[0] = '{8'b00_01_00_01, 4'b0101};
    vecs[1] = '{8'b00_00_00_00, 4'b0000};
    vecs[2] = '{8'b01_01_01_01, 4'b1111};
    vecs[3] = '{8'b01_11_00_01, 4'b1001};
    vecs[4] = '{8'b11_11_11_11, 4'b0000};
    vecs[5] = '{8'b01_00_01_00, 4'b1010};

    rst_i        = 1'b1;
    mode_i       = '0;
    blink_half_i = 8'd2;
    exit_value_i = '0;
    exit_valid_i = 1'b0;

    // Prescaler after release.
    do_reset();
    while (t <= 11) begin
      chk("tick_seq", 32'(tick_o), 32'(t == 3 || t == 7 || t == 11));
      next_cycle();
    end

    // Static modes from the table, one-cycle latency each.
    for (int i = 0; i < 6; i++) begin
      mode_i = vecs[i].mode;
      next_cycle();
      chk("table_led", 32'(led_o), 32'(vecs[i].exp_led));
    end

    // Exit code 3 with a later ignored valid carrying 5.
    mode_i = 8'h03;
    do_reset();
    while (t <= 44) begin
      if (t >= 1) begin
        chk("code3_led", 32'(led_o[0]),
            32'((t >= 3 && t <= 4) || (t >= 9 && t <= 12) || (t >= 17 && t <= 20) || (t >= 37 && t <= 40)));
        chk("code3_latched", 32'(exit_latched_o), 32'(t >= 2));
        chk("code3_code", 32'(exit_code_o), (t >= 2) ? 32'd3 : 32'd0);
      end
      exit_valid_i = (t == 1 || t == 14);
      exit_value_i = (t == 1) ? 32'h13 : 32'h5;
      next_cycle();
    end
    exit_valid_i = 1'b0;

    // Exit success: code 0 gives solid on.
    do_reset();
    while (t <= 30) begin
      chk("solid_led", 32'(led_o[0]), 32'(t >= 4));
      chk("solid_latched", 32'(exit_latched_o), 32'(t >= 3));
      chk("solid_code", 32'(exit_code_o), 32'd0);
      exit_valid_i = (t == 2);
      exit_value_i = 32'h10;
      next_cycle();
    end
    exit_valid_i = 1'b0;

    // Latch on a tick cycle, then reset while flashing off.
    mode_i = 8'b0000_0111;
    do_reset();
    while (t <= 11) begin
      if (t >= 1) begin
        chk("tickcap_led", 32'(led_o),
            32'({2'b00, (t <= 10), (t >= 5 && t <= 8)}));
        chk("tickcap_latched", 32'(exit_latched_o), 32'(t >= 4 && t <= 10));
        chk("tickcap_code", 32'(exit_code_o), (t >= 4 && t <= 10) ? 32'd2 : 32'd0);
      end
      exit_valid_i = (t == 3);
      exit_value_i = 32'h2;
      rst_i        = (t == 10);
      next_cycle();
    end
    rst_i        = 1'b0;
    exit_valid_i = 1'b0;

    // Valid coinciding with reset is not latched.
    mode_i       = 8'h03;
    rst_i        = 1'b1;
    exit_valid_i = 1'b1;
    exit_value_i = 32'h1;
    @(negedge clk_i);
    rst_i        = 1'b0;
    exit_valid_i = 1'b0;
    t            = 0;
    while (t <= 8) begin
      chk("rstvalid_latched", 32'(exit_latched_o), 32'd0);
      chk("rstvalid_led", 32'(led_o), 32'd0);
      next_cycle();
    end

    // Randomized runs across blink half-periods.
    run_random(600, 8'd2);
    run_random(600, 8'd0);
    run_random(600, 8'd1);
    run_random(600, 8'd3);
    run_random(600, 8'($urandom_range(1, 5)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fpga_status_indicator.md
# fpga_status_indicator

Parametrised board-level status indicator for the FPGA top-level wrappers. It drives up to NUM_CH LEDs with per-channel modes: off, on, programmable blink, and exit-code flashing. It replaces the fixed free-running clock-divider LED with a shared tick prescaler, a blink generator, and a latched exit-status pattern sequencer. It sits beside the SoC top in the wrapper, fed by the generated clock, the wrapper reset and the SoC exit_value/exit_valid outputs.

## Interface
- NUM_CH, 4: number of LED channels (1..16)
- TICK_DIV, 12_500_000: clock cycles per tick (>=2)
- HALF_W, 8: width of the blink half-period field, in ticks
- CODE_W, 4: number of exit_value LSBs used as the flash count
- GAP_TICKS, 8: off ticks between flash bursts (>=1)

- clk_i  in  1  system clock, generated clock domain
- rst_i  in  1  synchronous reset, active-high
- mode_i  in  2*NUM_CH  per-channel mode, channel k in bits [2k+1:2k]: 00 off, 01 on, 10 blink, 11 exit-code
- blink_half_i  in  HALF_W  blink half-period in ticks, shared by all channels
- exit_value_i  in  32  SoC exit value
- exit_valid_i  in  1  SoC exit valid (level)
- led_o  out  NUM_CH  registered LED drive, 1 = lit
- tick_o  out  1  single-cycle tick pulse
- exit_latched_o  out  1  exit value captured
- exit_code_o  out  CODE_W  captured exit_value_i[CODE_W-1:0]

## Operation
- Prescaler: counter 0..TICK_DIV-1. tick_o=1 in the cycle the counter equals TICK_DIV-1; the counter then wraps to 0.
- Blink: half counter advances on tick. When it reaches max(blink_half_i,1)-1 on a tick, it clears and phase toggles. blink_half_i==0 is treated as 1. A change of blink_half_i takes effect at the next compare. Blink-mode LED = phase.
- Exit latch: in the first cycle with exit_valid_i=1 and exit_latched_o=0, capture exit_value_i[CODE_W-1:0] and set exit_latched_o. Later exit_valid_i and exit_value_i changes are ignored until reset.
- Exit sequencer FSM: IDLE, SOLID, FLASH_ON, FLASH_OFF, GAP.
  - IDLE: leave on latch. Go to SOLID if code==0, else FLASH_ON with flash_cnt=0.
  - SOLID: terminal (success indication).
  - FLASH_ON: on tick, go to FLASH_OFF.
  - FLASH_OFF: on tick, go to GAP with gap_cnt=0 if flash_cnt==code-1; otherwise flash_cnt++ and go to FLASH_ON.
  - GAP: on tick, gap_cnt++. When gap_cnt==GAP_TICKS-1 on a tick, go to FLASH_ON with flash_cnt=0.
  - The first FLASH_ON after the latch lasts from the latch until the next tick (partial tick allowed).
- Exit-mode LED = 1 in SOLID or FLASH_ON, else 0. In IDLE every exit-mode channel is dark.
- Per-channel output: led_o[k] is registered from mode_i[2k+1:2k] through the selection above.
- Counters: no counter overflows. flash_cnt is CODE_W wide, gap_cnt is clog2(GAP_TICKS+1) wide, the half counter is HALF_W wide.

## Timing
- Reset values: led_o=0, tick_o=0, exit_latched_o=0, exit_code_o=0. Prescaler, half counter, phase, flash_cnt and gap_cnt are 0. FSM is IDLE.
- rst_i dominates every other input in the same cycle, including exit_valid_i. Reset mid-pattern returns to IDLE and clears the latch.
- First tick_o is in cycle TICK_DIV-1 after reset deassertion (cycle 0 = first cycle with rst_i=0). After that, tick_o fires every TICK_DIV cycles.
- Latch: exit_latched_o and exit_code_o are high/valid the cycle after the capture cycle. The FSM leaves IDLE in that same next cycle.
- led_o latency is 1 cycle from the registered source (mode_i change, FSM state, phase). A mode change mid-pattern does not disturb the FSM or the blink phase.
- Latch coinciding with a tick: the latch is taken. The FSM enters FLASH_ON/SOLID, and that tick does not advance it.
- exit_valid_i high for one cycle is sufficient.

## Test plan
- Reset/prescaler (TICK_DIV=4): hold rst_i for 3 cycles, then release -> all outputs 0 during reset; tick_o high in cycles 3, 7, 11.
- Static modes: mode_i=8'b00_01_00_01 -> led_o=4'b0101 one cycle after the change; setting mode_i=0 -> led_o=0 one cycle later.
- Blink (TICK_DIV=4, blink_half_i=2): channel 0 in mode 10 -> led_o[0] toggles every 8 cycles. blink_half_i=0 -> toggles every 4 cycles.
- Exit code 3 (TICK_DIV=4, GAP_TICKS=3, channel 0 in mode 11): pulse exit_valid_i with exit_value_i=32'h13 -> exit_code_o=3. Pattern shows 3 lit ticks, each followed by 1 dark tick, then 3 dark gap ticks; this repeats. A second exit_valid_i with value 5 is ignored.
- Exit success: exit_value_i=32'h10 (code 0) -> exit_latched_o=1 and led_o[0] solid 1 thereafter.
- Reset mid-pattern and simultaneous events: rst_i asserted during FLASH_OFF -> led_o=0 and exit_latched_o=0 next cycle. exit_valid_i asserted in the same cycle as rst_i -> not latched. exit_valid_i asserted on a tick cycle -> FLASH_ON entered and held until the following tick.
